// File: rtl/neuron_lut_loader.sv
// Runtime-loadable 2**IN_BITS x OUT_BITS neuron truth table.
// Byte-stream configuration port in, single-cycle registered lookups out.
module neuron_lut_loader #(
  parameter int IN_BITS  = 6,
  parameter int OUT_BITS = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cfg_start,
  input  logic                cfg_valid,
  input  logic [7:0]          cfg_data,
  output logic                cfg_ready,
  output logic                cfg_done,
  output logic                cfg_err,
  output logic                loaded,
  input  logic                lut_valid_in,
  input  logic [IN_BITS-1:0]  lut_in,
  output logic                lut_valid_out,
  output logic [OUT_BITS-1:0] lut_out
);

  // state | meaning
  // EMPTY | no table yet, lookups dropped
  // LOAD  | accepting config bytes, lookups dropped
  // READY | table complete, lookups served

  localparam int DEPTH  = 2**IN_BITS;
  localparam int EPB    = 8 / OUT_BITS;
  localparam int NBYTES = DEPTH / EPB;
  localparam int CW     = $clog2(NBYTES);

  typedef enum logic [1:0] {EMPTY, LOAD, READY} state_t;

  state_t            state;
  logic [CW-1:0]     cnt;
  logic [OUT_BITS-1:0] mem [DEPTH];
  logic              accept;
  logic              err_set;

  assign cfg_ready = (state == LOAD) && !cfg_start;
  assign accept    = cfg_valid && cfg_ready;
  assign err_set   = cfg_valid && ((state != LOAD) || cfg_start);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= EMPTY;
      cnt      <= '0;
      cfg_done <= 1'b0;
      cfg_err  <= 1'b0;
      loaded   <= 1'b0;
    end else begin
      cfg_done <= 1'b0;
      if (cfg_start) begin
        state  <= LOAD;
        cnt    <= '0;
        loaded <= 1'b0;
      end else if (accept) begin
        cnt <= cnt + CW'(1);
        if (cnt == CW'(NBYTES - 1)) begin
          state    <= READY;
          loaded   <= 1'b1;
          cfg_done <= 1'b1;
        end
      end
      // a coincident protocol error outranks the clear from cfg_start
      if (err_set)
        cfg_err <= 1'b1;
      else if (cfg_start)
        cfg_err <= 1'b0;
    end
  end

  // Table storage is deliberately unreset; `loaded` gates every read.
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int j = 0; j < EPB; j++)
        mem[IN_BITS'(EPB * int'(cnt) + j)] <= cfg_data[OUT_BITS*j +: OUT_BITS];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lut_valid_out <= 1'b0;
      lut_out       <= '0;
    end else begin
      lut_valid_out <= lut_valid_in && loaded;
      if (lut_valid_in && loaded)
        lut_out <= mem[lut_in];
    end
  end

endmodule

// File: tb/tb_neuron_lut_loader.sv
// Scoreboard bench for neuron_lut_loader: a behavioural table model predicts
// every lookup, control output and hold behaviour cycle by cycle.
module tb_neuron_lut_loader;

  localparam int M_LOAD  = 1;
  localparam int M_READY = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       cfg_start = 1'b0;
  logic       cfg_valid = 1'b0;
  logic [7:0] cfg_data = 8'h00;
  logic       cfg_ready, cfg_done, cfg_err, loaded;
  logic       lut_valid_in = 1'b0;
  logic [5:0] lut_in = 6'h00;
  logic       lut_valid_out;
  logic [1:0] lut_out;

  int n_cmp = 0;
  int n_bad = 0;

  logic [1:0] m_mem [64];
  int         m_st;
  int         m_cnt;
  bit         m_loaded, m_done, m_err, m_lv;
  logic [1:0] m_lut;
  logic [1:0] sbq [$];

  neuron_lut_loader #(.IN_BITS(6), .OUT_BITS(2)) dut (
    .clk(clk), .rst(rst),
    .cfg_start(cfg_start), .cfg_valid(cfg_valid), .cfg_data(cfg_data),
    .cfg_ready(cfg_ready), .cfg_done(cfg_done), .cfg_err(cfg_err), .loaded(loaded),
    .lut_valid_in(lut_valid_in), .lut_in(lut_in),
    .lut_valid_out(lut_valid_out), .lut_out(lut_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst && lut_valid_out) begin
      if (sbq.size() == 0)
        chk("sb_unexpected", 1, 0);
      else
        chk("sb_lut", {30'd0, lut_out}, {30'd0, sbq.pop_front()});
    end
  end

  task automatic model_reset();
    m_st = 0; m_cnt = 0;
    m_loaded = 0; m_done = 0; m_err = 0; m_lv = 0; m_lut = 2'b00;
    sbq.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    cfg_start = 0; cfg_valid = 0; lut_valid_in = 0;
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  // One clock of stimulus: check registered outputs from the previous edge,
  // drive inputs, check cfg_ready, then advance the model across the edge.
  task automatic cyc(input bit s, input bit v, input logic [7:0] d,
                     input bit lv, input logic [5:0] la);
    bit exp_ready, acc, eset;
    @(negedge clk);
    chk("cfg_done", {31'd0, cfg_done}, {31'd0, m_done});
    chk("cfg_err", {31'd0, cfg_err}, {31'd0, m_err});
    chk("loaded", {31'd0, loaded}, {31'd0, m_loaded});
    chk("lut_valid_out", {31'd0, lut_valid_out}, {31'd0, m_lv});
    chk("lut_out_hold", {30'd0, lut_out}, {30'd0, m_lut});
    cfg_start = s; cfg_valid = v; cfg_data = d;
    lut_valid_in = lv; lut_in = la;
    #1;
    exp_ready = (m_st == M_LOAD) && !s;
    chk("cfg_ready", {31'd0, cfg_ready}, {31'd0, exp_ready});
    acc  = v && exp_ready;
    eset = v && ((m_st != M_LOAD) || s);
    if (lv && m_loaded) begin
      sbq.push_back(m_mem[la]);
      m_lut = m_mem[la];
      m_lv  = 1;
    end else begin
      m_lv = 0;
    end
    m_done = 0;
    if (s) begin
      m_st = M_LOAD; m_cnt = 0; m_loaded = 0;
    end else if (acc) begin
      for (int j = 0; j < 4; j++) m_mem[4*m_cnt + j] = d[2*j +: 2];
      if (m_cnt == 15) begin
        m_st = M_READY; m_loaded = 1; m_done = 1; m_cnt = 0;
      end else begin
        m_cnt++;
      end
    end
    if (eset) m_err = 1;
    else if (s) m_err = 0;
  endtask

  task automatic idle();
    cyc(0, 0, 8'h00, 0, 6'h00);
  endtask

  task automatic load16(input bit rnd, input logic [7:0] fixed, input bit gaps);
    logic [7:0] b;
    cyc(1, 0, 8'h00, 0, 6'h00);
    for (int k = 0; k < 16; k++) begin
      if (gaps) idle();
      b = rnd ? 8'($urandom) : fixed;
      cyc(0, 1, b, 0, 6'h00);
    end
  endtask

  task automatic sweep();
    for (int a = 0; a < 64; a++) cyc(0, 0, 8'h00, 1, 6'(a));
    idle();
  endtask

  initial begin
    model_reset();
    #12 rst = 1'b1;
    chk("rst_lut_out", {30'd0, lut_out}, 0);
    chk("rst_cfg_ready", {31'd0, cfg_ready}, 0);

    // lookup before any table is loaded is dropped
    cyc(0, 0, 8'h00, 1, 6'h15);
    idle(); idle();

    // back-to-back load of E4; last byte carries a lookup (dropped),
    // the cfg_done cycle carries a lookup (served)
    cyc(1, 0, 8'h00, 0, 6'h00);
    for (int k = 0; k < 15; k++) cyc(0, 1, 8'hE4, 0, 6'h00);
    cyc(0, 1, 8'hE4, 1, 6'h05);
    cyc(0, 0, 8'h00, 1, 6'h02);
    cyc(0, 0, 8'h00, 1, 6'h00);
    cyc(0, 0, 8'h00, 1, 6'h01);
    cyc(0, 0, 8'h00, 1, 6'h02);
    cyc(0, 0, 8'h00, 1, 6'h03);
    cyc(0, 0, 8'h00, 1, 6'h3F);
    idle();

    // same table with cfg_valid gaps, then random contents with gaps
    load16(0, 8'hE4, 1);
    idle();
    sweep();
    load16(1, 8'h00, 1);
    idle();
    sweep();

    // restart mid-load; lookup alongside start is served from old table
    cyc(1, 0, 8'h00, 1, 6'h07);
    for (int k = 0; k < 5; k++) cyc(0, 1, 8'hFF, 1, 6'(k));
    cyc(1, 0, 8'h00, 1, 6'h01);
    for (int k = 0; k < 16; k++) cyc(0, 1, 8'h00, 1, 6'(k + 20));
    idle();
    sweep();

    // random table, then protocol errors
    load16(1, 8'h00, 0);
    idle();
    cyc(0, 1, 8'hAA, 0, 6'h00);
    cyc(0, 0, 8'h00, 1, 6'h00);
    idle();
    sweep();
    cyc(1, 0, 8'h00, 0, 6'h00);
    cyc(1, 1, 8'h55, 0, 6'h00);
    for (int k = 0; k < 16; k++) cyc(0, 1, 8'($urandom), 0, 6'h00);
    idle();
    sweep();

    // reset after byte 9 of a load, then a fresh load
    cyc(1, 0, 8'h00, 0, 6'h00);
    for (int k = 0; k < 9; k++) cyc(0, 1, 8'($urandom), 0, 6'h00);
    do_reset();
    idle(); idle();
    load16(1, 8'h00, 0);
    idle();
    sweep();

    idle(); idle();
    chk("sb_drain", sbq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
